// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
// Bus between the sequencer, the instruction memory and the ALU.
//   InstAddr  [7:0] : program counter presented to instruction memory
//   InstIn    [8:0] : instruction at InstAddr (combinational memory)
//   AluOp     [2:0] : registered ALU opcode
//   AluIn1/2  [7:0] : registered ALU operands
//   AluResult [7:0] : combinational ALU result
// master = sequencer side, slave = memory/ALU side.
interface alu_sequencer_if;
  logic [7:0] InstAddr;
  logic [8:0] InstIn;
  logic [2:0] AluOp;
  logic [7:0] AluIn1;
  logic [7:0] AluIn2;
  logic [7:0] AluResult;

  modport master (
    output InstAddr,
    output AluOp,
    output AluIn1,
    output AluIn2,
    input  InstIn,
    input  AluResult
  );

  modport slave (
    input  InstAddr,
    input  AluOp,
    input  AluIn1,
    input  AluIn2,
    output InstIn,
    output AluResult
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle control unit for the 8-bit ALU. Fetches 9-bit instructions, holds a 4 x 8-bit
// register file, issues ALU opcode/operands, captures the result, then writes back and
// resolves branches. Non-halt instructions take FETCH, DECODE, EXEC, WB; HALT takes
// FETCH, DECODE.
// Ports:
//   Clk     : rising-edge clock
//   Reset   : synchronous active-high reset, highest priority
//   Start   : begin execution (honoured only in IDLE or HALTED)
//   Done    : high while HALTED
//   DbgSel  : register-file read select
//   DbgData : combinational read of r[DbgSel]
//   bus     : instruction memory / ALU bus (master side)
module alu_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic            Done,
  input  logic [1:0]      DbgSel,
  output logic [7:0]      DbgData,
  alu_sequencer_if.master bus
);

  localparam logic [2:0] OpXor  = 3'b000;
  localparam logic [2:0] OpBeq  = 3'b001;
  localparam logic [2:0] OpAddi = 3'b010;
  localparam logic [2:0] OpAndi = 3'b011;
  localparam logic [2:0] OpRls  = 3'b100;
  localparam logic [2:0] OpHalt = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalted
  } state_e;

  state_e     state_q;
  logic [7:0] pc_q;
  logic [8:0] ir_q;
  logic [7:0] regs_q [4];
  logic [7:0] res_q;
  logic       taken_q;
  logic [2:0] aluop_q;
  logic [7:0] aluin1_q;
  logic [7:0] aluin2_q;
  logic       done_q;

  // Instruction fields, valid from DECODE onward (IR is loaded at the end of FETCH).
  logic [2:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [3:0] imm;
  logic [7:0] imm_sext;
  logic [7:0] imm_zext;
  logic [7:0] pc_inc;
  logic [7:0] pc_branch;
  logic       writes_reg;

  assign op        = ir_q[8:6];
  assign ra        = ir_q[5:4];
  assign rb        = ir_q[3:2];
  assign imm       = ir_q[3:0];
  assign imm_sext  = {{4{imm[3]}}, imm};
  assign imm_zext  = {4'b0000, imm};
  assign pc_inc    = pc_q + 8'd1;
  assign pc_branch = pc_inc + imm_sext;  // 8-bit add, wraps naturally

  assign writes_reg = (op == OpXor) || (op == OpAddi) || (op == OpAndi) || (op == OpRls);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      res_q    <= '0;
      taken_q  <= 1'b0;
      aluop_q  <= '0;
      aluin1_q <= '0;
      aluin2_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (Start) begin
            pc_q    <= PC_RESET;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          ir_q    <= bus.InstIn;
          state_q <= StDecode;
        end
        StDecode: begin
          if (op == OpHalt) begin
            done_q  <= 1'b1;
            state_q <= StHalted;
          end else begin
            aluop_q  <= op;
            // beq compares r0 against r[ra]
            aluin1_q <= (op == OpBeq) ? regs_q[0] : regs_q[ra];
            case (op)
              OpXor:          aluin2_q <= regs_q[rb];
              OpBeq:          aluin2_q <= regs_q[ra];
              OpAndi, OpRls:  aluin2_q <= imm_zext;  // ALU uses only [2:0] for rls
              default:        aluin2_q <= imm_sext;  // addi and NOPs
            endcase
            state_q <= StExec;
          end
        end
        StExec: begin
          res_q   <= bus.AluResult;
          taken_q <= (bus.AluResult == 8'h00);
          state_q <= StWb;
        end
        StWb: begin
          if (writes_reg) begin
            regs_q[ra] <= res_q;
          end
          pc_q    <= ((op == OpBeq) && taken_q) ? pc_branch : pc_inc;
          state_q <= StFetch;
        end
        StHalted: begin
          if (Start) begin
            pc_q    <= PC_RESET;
            done_q  <= 1'b0;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.InstAddr = pc_q;
  assign bus.AluOp    = aluop_q;
  assign bus.AluIn1   = aluin1_q;
  assign bus.AluIn2   = aluin2_q;
  assign Done         = done_q;
  assign DbgData      = regs_q[DbgSel];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Directed programs run against an instruction-level model of the CPU (PC + 4 registers);
// every instruction is followed cycle by cycle, checking PC, Done, ALU issue and register
// contents. Literal register/PC values pin the model for the hand-worked programs.
module tb_alu_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Done;
  logic [1:0] DbgSel;
  logic [7:0] DbgData;

  logic [8:0] mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  // Instruction-level model state
  logic [7:0] m_pc;
  logic [7:0] m_r [4];

  localparam logic [8:0] Halt = 9'b111_00_0000;
  localparam logic [8:0] Nop5 = 9'b101_00_0000;
  localparam logic [8:0] Nop6 = 9'b110_00_0000;

  alu_sequencer_if bus();

  alu_sequencer #(.PC_RESET(8'h00)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Done    (Done),
    .DbgSel  (DbgSel),
    .DbgData (DbgData),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // Environment: instruction memory and ALU
  assign bus.InstIn = mem[bus.InstAddr];

  always_comb begin
    case (bus.AluOp)
      3'b000:  bus.AluResult = bus.AluIn1 ^ bus.AluIn2;
      3'b001:  bus.AluResult = bus.AluIn1 - bus.AluIn2;
      3'b010:  bus.AluResult = bus.AluIn1 + bus.AluIn2;
      3'b011:  bus.AluResult = bus.AluIn1 & bus.AluIn2;
      3'b100:  bus.AluResult = rotl8(bus.AluIn1, bus.AluIn2[2:0]);
      default: bus.AluResult = 8'hA5;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = Halt;
  endtask

  // Sweeps DbgSel over all registers; uses 4 time units of the low clock phase.
  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      DbgSel = i[1:0];
      #1;
      chk($sformatf("reg_r%0d", i), DbgData, m_r[i]);
    end
  endtask

  task automatic dbg_lit(input string name, input logic [1:0] sel, input logic [7:0] exp);
    DbgSel = sel;
    #1;
    chk(name, DbgData, exp);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    start_cyc = cyc;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Called at the negedge of a FETCH cycle; returns at the next FETCH (or in HALTED).
  task automatic exec_one(output bit halted);
    logic [8:0] inst;
    logic [2:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] imm;
    logic [7:0] sx;
    logic [7:0] zx;
    logic [7:0] e_in1;
    logic [7:0] e_in2;
    inst = mem[m_pc];
    op   = inst[8:6];
    ra   = inst[5:4];
    rb   = inst[3:2];
    imm  = inst[3:0];
    sx   = {{4{imm[3]}}, imm};
    zx   = {4'b0000, imm};
    halted = 1'b0;

    chk("fetch_addr", bus.InstAddr, m_pc);
    chk("fetch_done", Done, 1'b0);
    @(negedge Clk);
    chk("decode_addr", bus.InstAddr, m_pc);
    check_regs();
    if (op == 3'b111) begin
      @(negedge Clk);
      chk("halt_done", Done, 1'b1);
      chk("halt_addr", bus.InstAddr, m_pc);
      done_cyc = cyc;
      halted = 1'b1;
      return;
    end

    e_in1 = (op == 3'b001) ? m_r[0] : m_r[ra];
    case (op)
      3'b000:         e_in2 = m_r[rb];
      3'b001:         e_in2 = m_r[ra];
      3'b011, 3'b100: e_in2 = zx;
      default:        e_in2 = sx;
    endcase

    @(negedge Clk);
    chk("exec_aluop", bus.AluOp, op);
    chk("exec_in1", bus.AluIn1, e_in1);
    chk("exec_in2", bus.AluIn2, e_in2);
    @(negedge Clk);
    chk("wb_aluop", bus.AluOp, op);
    chk("wb_in1", bus.AluIn1, e_in1);
    chk("wb_in2", bus.AluIn2, e_in2);

    if (op == 3'b001 && m_r[0] == m_r[ra]) m_pc = m_pc + 8'd1 + sx;
    else                                    m_pc = m_pc + 8'd1;
    case (op)
      3'b000:  m_r[ra] = m_r[ra] ^ m_r[rb];
      3'b010:  m_r[ra] = m_r[ra] + sx;
      3'b011:  m_r[ra] = m_r[ra] & zx;
      3'b100:  m_r[ra] = rotl8(m_r[ra], imm[2:0]);
      default: ;
    endcase
    @(negedge Clk);
  endtask

  task automatic run_prog();
    bit h;
    h = 1'b0;
    for (int k = 0; k < 64 && !h; k++) exec_one(h);
    chk("halt_reached", h, 1'b1);
  endtask

  initial begin
    bit h;
    Reset  = 1'b1;
    Start  = 1'b0;
    DbgSel = 2'd0;
    clear_mem();
    @(negedge Clk);
    do_reset();

    // Reset state
    chk("rst_addr", bus.InstAddr, 8'h00);
    chk("rst_aluop", bus.AluOp, 3'b000);
    chk("rst_in1", bus.AluIn1, 8'h00);
    chk("rst_in2", bus.AluIn2, 8'h00);
    chk("rst_done", Done, 1'b0);
    check_regs();

    // addi r1,+5 ; halt
    mem[0] = 9'b010_01_0101;
    mem[1] = Halt;
    pulse_start();
    run_prog();
    chk("t1_done_cycle", done_cyc - start_cyc, 7);
    dbg_lit("t1_r1", 2'd1, 8'h05);

    // Restart from HALTED, Start during DECODE ignored, Reset during EXEC
    pulse_start();
    chk("t6_fetch_addr", bus.InstAddr, 8'h00);
    chk("t6_done_fell", Done, 1'b0);
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("t6_exec_aluop", bus.AluOp, 3'b010);
    chk("t6_exec_addr", bus.InstAddr, 8'h00);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    chk("t6_addr", bus.InstAddr, 8'h00);
    chk("t6_aluop", bus.AluOp, 3'b000);
    chk("t6_in1", bus.AluIn1, 8'h00);
    chk("t6_in2", bus.AluIn2, 8'h00);
    chk("t6_done", Done, 1'b0);
    dbg_lit("t6_r1", 2'd1, 8'h00);
    @(negedge Clk);
    @(negedge Clk);
    chk("t6_idle_addr", bus.InstAddr, 8'h00);
    chk("t6_idle_aluop", bus.AluOp, 3'b000);

    // addi r0,-1 ; addi r0,+1 ; halt
    clear_mem();
    mem[0] = 9'b010_00_1111;
    mem[1] = 9'b010_00_0001;
    pulse_start();
    exec_one(h);
    dbg_lit("t2_r0_ff", 2'd0, 8'hFF);
    exec_one(h);
    dbg_lit("t2_r0_00", 2'd0, 8'h00);
    run_prog();

    // addi r2,+3 ; rls r2,4 (imm 1100) ; rls r2,7 ; andi r2,1 ; halt
    do_reset();
    clear_mem();
    mem[0] = 9'b010_10_0011;
    mem[1] = 9'b100_10_1100;
    mem[2] = 9'b100_10_0111;
    mem[3] = 9'b011_10_0001;
    pulse_start();
    exec_one(h);
    dbg_lit("t3_r2_03", 2'd2, 8'h03);
    exec_one(h);
    dbg_lit("t3_r2_30", 2'd2, 8'h30);
    exec_one(h);
    dbg_lit("t3_r2_18", 2'd2, 8'h18);
    exec_one(h);
    dbg_lit("t3_r2_00", 2'd2, 8'h00);
    run_prog();

    // addi r1,+6 ; addi r3,+3 ; xor r1,r3 ; halt
    do_reset();
    clear_mem();
    mem[0] = 9'b010_01_0110;
    mem[1] = 9'b010_11_0011;
    mem[2] = 9'b000_01_1100;
    pulse_start();
    run_prog();
    dbg_lit("t4_r1", 2'd1, 8'h05);
    dbg_lit("t4_r3", 2'd3, 8'h03);

    // beq r1,+2 taken (r0 = r1 = 0)
    do_reset();
    clear_mem();
    mem[0] = 9'b001_01_0010;
    mem[1] = 9'b010_00_0001;
    pulse_start();
    exec_one(h);
    chk("t5_taken_addr", bus.InstAddr, 8'h03);
    run_prog();

    // beq r1,+2 not taken (r1 = 1), run after a restart from HALTED
    clear_mem();
    mem[0] = 9'b010_01_0001;
    m_pc = 8'h00;
    pulse_start();
    run_prog();
    clear_mem();
    mem[0] = 9'b001_01_0010;
    mem[3] = 9'b010_00_0001;
    m_pc = 8'h00;
    pulse_start();
    exec_one(h);
    chk("t5_nt_addr", bus.InstAddr, 8'h01);
    run_prog();
    dbg_lit("t5_nt_r1", 2'd1, 8'h01);
    dbg_lit("t5_nt_r0", 2'd0, 8'h00);

    // PC wrap through 256 NOPs, then beq r0,-1 at PC 0 (always taken)
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = (i % 7 == 3) ? Nop6 : Nop5;
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        chk("t7_addr_ff", bus.InstAddr, 8'hFF);
        mem[0] = 9'b001_00_1111;
      end
      exec_one(h);
    end
    chk("t7_addr_wrap", bus.InstAddr, 8'h00);
    exec_one(h);
    chk("t7_beq_back", bus.InstAddr, 8'h00);
    do_reset();
    chk("t7_rst_addr", bus.InstAddr, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
